// File: rtl/watch_set_ctrl.sv
// Mode/set controller for the digital watch.
// Three raw buttons (mode, pos, inc) are synchronized and debounced. A
// CLOCK/SET state machine then drives the counter run enable, one-cycle
// increment strobes and a blinking per-digit display enable mask.
// Button index used internally: 0 = mode, 1 = pos, 2 = inc.
// Among presses that arrive in the same cycle, index 0 wins, then 1, then 2.
module watch_set_ctrl #(
    parameter int DB_CNT     = 1_000_000,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic       o_cnt_run,
    output logic       o_inc_sec,
    output logic       o_inc_min,
    output logic       o_inc_hour,
    output logic [5:0] o_digit_enb
);

    localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam int BLW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CNT - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);

    typedef enum logic {
        ST_CLOCK = 1'b0,
        ST_SET   = 1'b1
    } state_t;

    // Input conditioning state
    logic [2:0]     raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     level_q, level_d;
    logic [2:0]     level_prev_q;
    logic [2:0]     press_q, press_d;
    logic [DBW-1:0] db_cnt_q [3];
    logic [DBW-1:0] db_cnt_d [3];

    // Controller state
    state_t         state_q, state_d;
    logic [1:0]     pos_q, pos_d;
    logic [2:0]     inc_q, inc_d;
    logic           run_q, run_d;
    logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
    logic           phase_q, phase_d;
    logic [5:0]     enb_q, enb_d;
    logic           restart;

    assign raw = {i_sw_inc, i_sw_pos, i_sw_mode};

    // Debounce: the level flips only after DB_CNT consecutive differing samples
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
        press_d = level_q & ~level_prev_q;
    end

    // Synchronizers, debounce counters and registered press edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // Next-state, strobe, blink and display-mask decisions
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        inc_d   = '0;
        restart = 1'b0;
        if (state_q == ST_CLOCK) begin
            if (press_q[0]) begin
                state_d = ST_SET;
                pos_d   = 2'd0;
                restart = 1'b1;
            end
        end else begin
            if (press_q[0]) begin
                state_d = ST_CLOCK;
            end else if (press_q[1]) begin
                pos_d   = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
                restart = 1'b1;
            end else if (press_q[2]) begin
                inc_d   = 3'b001 << pos_q;
                restart = 1'b1;
            end
        end

        // Blink timer is parked at "on" outside SET and on every restart
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (state_d == ST_CLOCK || restart) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLW'(1);
        end

        enb_d = 6'h3F;
        if (state_d == ST_SET) begin
            case (pos_d)
                2'd0:    enb_d[1:0] = {2{phase_d}};
                2'd1:    enb_d[3:2] = {2{phase_d}};
                2'd2:    enb_d[5:4] = {2{phase_d}};
                default: enb_d      = 6'h3F;
            endcase
        end
        run_d = (state_d == ST_CLOCK);
    end

    // Controller registers; every output comes straight from one of these
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLOCK;
            pos_q       <= 2'd0;
            inc_q       <= '0;
            run_q       <= 1'b1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            enb_q       <= 6'h3F;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            inc_q       <= inc_d;
            run_q       <= run_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            enb_q       <= enb_d;
        end
    end

    assign o_mode      = (state_q == ST_SET);
    assign o_pos       = pos_q;
    assign o_cnt_run   = run_q;
    assign o_inc_sec   = inc_q[0];
    assign o_inc_min   = inc_q[1];
    assign o_inc_hour  = inc_q[2];
    assign o_digit_enb = enb_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl with short debounce and blink periods.
// A reference model predicts the full output word for every clock edge and
// pushes it into a queue; a monitor pops one entry per cycle and compares.
module tb_watch_set_ctrl;

    localparam int DB = 4;
    localparam int BH = 8;
    localparam logic [12:0] RESET_VEC = {1'b0, 2'd0, 1'b1, 3'b000, 6'h3F};

    logic       clk;
    logic       rst;
    logic       sw_mode, sw_pos, sw_inc;
    logic       o_mode, o_cnt_run, o_inc_sec, o_inc_min, o_inc_hour;
    logic [1:0] o_pos;
    logic [5:0] o_digit_enb;

    logic [12:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;

    watch_set_ctrl #(.DB_CNT(DB), .BLINK_HALF(BH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_sw_mode  (sw_mode),
        .i_sw_pos   (sw_pos),
        .i_sw_inc   (sw_inc),
        .o_mode     (o_mode),
        .o_pos      (o_pos),
        .o_cnt_run  (o_cnt_run),
        .o_inc_sec  (o_inc_sec),
        .o_inc_min  (o_inc_min),
        .o_inc_hour (o_inc_hour),
        .o_digit_enb(o_digit_enb)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] dut_word();
        return {o_mode, o_pos, o_cnt_run, o_inc_hour, o_inc_min, o_inc_sec, o_digit_enb};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    endtask

    // Reference model: raw samples reach the debouncer two edges late; a level
    // flips after DB consecutive differing samples; a rising level acts on the
    // controller two edges later. Blink phase is derived from elapsed cycles.
    int   cyc = 0;
    bit   m_set;
    int   m_pos, m_restart;
    int   run[3], due[3];
    bit   lvl[3], h1[3], h2[3];
    logic [2:0] m_inc;

    always @(posedge clk) begin : model
        logic [2:0] rawv;
        logic [5:0] enb, sel;
        bit pr[3];
        rawv = {sw_inc, sw_pos, sw_mode};
        cyc++;
        if (rst) begin
            m_set = 0; m_pos = 0; m_restart = 0; m_inc = '0;
            for (int b = 0; b < 3; b++) begin
                run[b] = 0; due[b] = -1; lvl[b] = 0; h1[b] = 0; h2[b] = 0;
            end
            exp_q.push_back(RESET_VEC);
        end else begin
            for (int b = 0; b < 3; b++) pr[b] = (due[b] == cyc);
            m_inc = '0;
            if (pr[0]) begin
                m_set = !m_set;
                if (m_set) begin m_pos = 0; m_restart = cyc; end
            end else if (m_set && pr[1]) begin
                m_pos = (m_pos + 1) % 3; m_restart = cyc;
            end else if (m_set && pr[2]) begin
                m_inc[m_pos] = 1'b1; m_restart = cyc;
            end
            for (int b = 0; b < 3; b++) begin
                if (h2[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin
                        lvl[b] = h2[b];
                        run[b] = 0;
                        if (lvl[b]) due[b] = cyc + 2;
                    end
                end else begin
                    run[b] = 0;
                end
                h2[b] = h1[b];
                h1[b] = rawv[b];
            end
            sel = 6'b000011 << (2 * m_pos);
            if (!m_set || (((cyc - m_restart) / BH) % 2 == 0)) enb = 6'h3F;
            else enb = 6'h3F & ~sel;
            exp_q.push_back({m_set, 2'(m_pos), !m_set, m_inc[2], m_inc[1], m_inc[0], enb});
        end
    end

    // Monitor: one output word per cycle, o_pos only meaningful in SET
    always @(negedge clk) begin : monitor
        logic [12:0] exp, got;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = dut_word();
            if (rst) exp = RESET_VEC;
            else if (!exp[12]) begin
                exp[11:10] = 2'd0;
                got[11:10] = 2'd0;
            end
            check("out", got, exp);
        end
    end

    // Driver: apply a button pattern for n cycles, changing just after negedge
    task automatic drive(input bit m, input bit p, input bit i, input int n);
        sw_mode = m; sw_pos = p; sw_inc = i;
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        rst = 1'b1; sw_mode = 0; sw_pos = 0; sw_inc = 0;
        @(negedge clk); #2;

        // Reset held with buttons toggling
        repeat (8) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        drive(0, 0, 0, 2);
        rst = 1'b0;
        drive(0, 0, 0, 5);

        // Debounce: short glitch rejected, held press enters SET, blink runs
        drive(1, 0, 0, 3);
        drive(0, 0, 0, 10);
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 30);

        // Position cycling 1, 2, 0, then back to 1
        repeat (3) begin
            drive(0, 1, 0, 8);
            drive(0, 0, 0, 30);
        end
        drive(0, 1, 0, 8);
        drive(0, 0, 0, 20);

        // Increment held long in SET, then the same press in CLOCK
        drive(0, 0, 1, 100);
        drive(0, 0, 0, 20);
        drive(1, 0, 0, 8);
        drive(0, 0, 0, 20);
        drive(0, 0, 1, 20);
        drive(0, 0, 0, 20);

        // Collision of mode and inc while in SET
        drive(1, 0, 0, 8);
        drive(0, 0, 0, 20);
        drive(1, 0, 1, 10);
        drive(0, 0, 0, 20);

        // Async reset between edges while in SET with blink off
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 8);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst", dut_word(), RESET_VEC);
        sw_mode = 1'b1;
        @(negedge clk); #2;
        drive(1, 0, 0, 2);
        rst = 1'b0;
        drive(1, 0, 0, 15);
        drive(0, 0, 0, 20);

        // Random button activity
        repeat (250) begin
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 2) == 0), int'($urandom_range(1, 12)));
        end
        drive(0, 0, 0, 20);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
